// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns load/store intent into one registered
// req/ack bus transaction, stalls the pipeline meanwhile, and reports errors.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        AddrMode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Bus handshake: mem_req rises with all bus fields registered together and
  // they stay frozen until the single-cycle mem_ack (or the timeout) ends the
  // transfer on that same edge; mem_ack outside an open request is ignored.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_read_q, is_read_d;
  logic        byte_q, byte_d;
  logic [1:0]  lane_q, lane_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic        access;
  logic [7:0]  lane_byte;

  assign access = MemRead | MemWrite;

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (lane_q)
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    is_read_d  = is_read_q;
    byte_d     = byte_q;
    lane_d     = lane_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: begin
        cnt_d      = 8'd0;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        if (access) begin
          // A simultaneous read+write request is treated as a store.
          is_read_d = ~MemWrite;
          byte_d    = AddrMode;
          lane_d    = addr[1:0];
          if (!AddrMode && (addr[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            rdata_d    = 32'd0;
            state_d    = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = MemWrite;
            maddr_d = {addr[31:2], 2'b00};
            if (MemWrite) begin
              wstrb_d  = AddrMode ? (4'b0001 << addr[1:0]) : 4'b1111;
              mwdata_d = AddrMode ? {4{wdata[7:0]}} : wdata;
            end else begin
              wstrb_d  = 4'b0000;
              mwdata_d = 32'd0;
            end
            state_d = REQ;
          end
        end
      end

      REQ: begin
        if (mem_ack) begin
          if (is_read_q) begin
            rdata_d = byte_q ? {24'd0, lane_byte} : mem_rdata;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          cnt_d   = 8'd0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          rdata_d   = 32'd0;
          req_d     = 1'b0;
          we_d      = 1'b0;
          wstrb_d   = 4'b0000;
          cnt_d     = 8'd0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        // The instruction that just finished still drives MemRead/MemWrite
        // here; going straight to IDLE keeps it from retriggering.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= 32'd0;
      mwdata_q   <= 32'd0;
      wstrb_q    <= 4'b0000;
      rdata_q    <= 32'd0;
      is_read_q  <= 1'b0;
      byte_q     <= 1'b0;
      lane_q     <= 2'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      is_read_q  <= is_read_d;
      byte_q     <= byte_d;
      lane_q     <= lane_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  // A timed-out read is not a completed read, so it raises no rdata_valid.
  assign stall        = ((state_q == IDLE) && access) || (state_q == REQ);
  assign rdata        = rdata_q;
  assign rdata_valid  = (state_q == DONE) && is_read_q && !timeout_q;
  assign err_misalign = (state_q == DONE) && misalign_q;
  assign err_timeout  = (state_q == DONE) && timeout_q;
  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = maddr_q;
  assign mem_wdata    = mwdata_q;
  assign mem_wstrb    = wstrb_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4): loads, stores, byte lanes,
// misalignment, bus timeout and reset during an open request.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic        AddrMode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err_misalign;
  logic        err_timeout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_total;
  int n_pass;
  int n_fail;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .AddrMode     (AddrMode),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
    chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    chk({tag, ".rdata"}, rdata, 32'd0);
    chk({tag, ".rdata_valid"}, {31'd0, rdata_valid}, 32'd0);
    chk({tag, ".err_misalign"}, {31'd0, err_misalign}, 32'd0);
    chk({tag, ".err_timeout"}, {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; AddrMode = 1'b0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    // reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("idle_ack.rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("idle_ack.rdata", rdata, 32'd0);
    chk("idle_ack.mem_req", {31'd0, mem_req}, 32'd0);

    // LW 0x100, ack on first REQ cycle
    MemRead = 1'b1; AddrMode = 1'b0; addr = 32'h100;
    #1;
    chk("lw.idle_stall", {31'd0, stall}, 32'd1);
    chk("lw.idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("lw.req", {31'd0, mem_req}, 32'd1);
    chk("lw.addr", mem_addr, 32'h100);
    chk("lw.we", {31'd0, mem_we}, 32'd0);
    chk("lw.wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("lw.req_stall", {31'd0, stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("lw.done_stall", {31'd0, stall}, 32'd0);
    chk("lw.done_valid", {31'd0, rdata_valid}, 32'd1);
    chk("lw.done_rdata", rdata, 32'hDEADBEEF);
    chk("lw.done_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("lw.no_retrigger", {31'd0, mem_req}, 32'd0);
    MemRead = 1'b0;
    #1;
    chk("lw.idle_valid", {31'd0, rdata_valid}, 32'd0);
    chk("lw.rdata_hold", rdata, 32'hDEADBEEF);

    // LBU 0x103 -> lane 3
    MemRead = 1'b1; AddrMode = 1'b1; addr = 32'h103;
    tick();
    chk("lbu3.addr", mem_addr, 32'h100);
    chk("lbu3.wstrb", {28'd0, mem_wstrb}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hA1B2C3D4;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("lbu3.rdata", rdata, 32'h000000A1);
    chk("lbu3.valid", {31'd0, rdata_valid}, 32'd1);

    // LBU 0x101 -> lane 1
    tick();
    addr = 32'h101;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hA1B2C3D4;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("lbu1.rdata", rdata, 32'h000000C3);
    tick();
    MemRead = 1'b0;

    // SB 0x202, three wait cycles; inputs scrambled after sampling
    MemWrite = 1'b1; AddrMode = 1'b1; addr = 32'h202; wdata = 32'h12345678;
    #1;
    chk("sb.idle_stall", {31'd0, stall}, 32'd1);
    tick();
    addr = 32'hFFFF_FFFF; wdata = 32'h0; AddrMode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      #1;
      chk("sb.stall", {31'd0, stall}, 32'd1);
      chk("sb.req", {31'd0, mem_req}, 32'd1);
      chk("sb.we", {31'd0, mem_we}, 32'd1);
      chk("sb.addr", mem_addr, 32'h200);
      chk("sb.wstrb", {28'd0, mem_wstrb}, 32'h4);
      chk("sb.wdata", mem_wdata, 32'h78787878);
      tick();
    end
    mem_ack = 1'b0;
    #1;
    chk("sb.done_stall", {31'd0, stall}, 32'd0);
    chk("sb.done_valid", {31'd0, rdata_valid}, 32'd0);
    chk("sb.done_req", {31'd0, mem_req}, 32'd0);
    chk("sb.rdata_hold", rdata, 32'h000000C3);
    tick();
    MemWrite = 1'b0;

    // LW 0x300 with no ack: timeout after exactly 4 REQ cycles
    MemRead = 1'b1; AddrMode = 1'b0; addr = 32'h300;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to.req", {31'd0, mem_req}, 32'd1);
      chk("to.stall", {31'd0, stall}, 32'd1);
      tick();
    end
    chk("to.req_dropped", {31'd0, mem_req}, 32'd0);
    chk("to.err", {31'd0, err_timeout}, 32'd1);
    chk("to.rdata", rdata, 32'd0);
    chk("to.stall_rel", {31'd0, stall}, 32'd0);
    chk("to.valid", {31'd0, rdata_valid}, 32'd0);
    tick();
    MemRead = 1'b0;
    #1;
    chk("to.err_pulse", {31'd0, err_timeout}, 32'd0);

    // LW 0x400 to load a nonzero rdata
    MemRead = 1'b1; addr = 32'h400;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("lw2.rdata", rdata, 32'h13579BDF);
    tick();

    // misaligned LW 0x102: valid with zero data, no bus request
    addr = 32'h102;
    #1;
    chk("mlw.stall", {31'd0, stall}, 32'd1);
    tick();
    chk("mlw.err", {31'd0, err_misalign}, 32'd1);
    chk("mlw.valid", {31'd0, rdata_valid}, 32'd1);
    chk("mlw.rdata", rdata, 32'd0);
    chk("mlw.req", {31'd0, mem_req}, 32'd0);
    tick();
    MemRead = 1'b0;

    // misaligned SW 0x006
    MemWrite = 1'b1; AddrMode = 1'b0; addr = 32'h006; wdata = 32'hAAAA5555;
    #1;
    chk("msw.idle_stall", {31'd0, stall}, 32'd1);
    chk("msw.idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("msw.err", {31'd0, err_misalign}, 32'd1);
    chk("msw.stall", {31'd0, stall}, 32'd0);
    chk("msw.req", {31'd0, mem_req}, 32'd0);
    chk("msw.valid", {31'd0, rdata_valid}, 32'd0);
    tick();
    MemWrite = 1'b0;
    #1;
    chk("msw.err_pulse", {31'd0, err_misalign}, 32'd0);
    chk("msw.idle", {31'd0, stall}, 32'd0);

    // reset in 2nd REQ cycle, ack arrives the cycle after
    MemRead = 1'b1; addr = 32'h500;
    tick();
    tick();
    chk("rst.req_open", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; MemRead = 1'b0;
    tick();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #1;
    chk_all_zero("rst_mid");
    tick();
    mem_ack = 1'b0;
    #1;
    chk("rst.ack_ignored_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst.ack_ignored_rdata", rdata, 32'd0);
    chk("rst.ack_ignored_req", {31'd0, mem_req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage against a multi-cycle data memory that uses a req/ack handshake.
- Converts the pipeline's MemRead/MemWrite/AddrMode/funct3 intent into word-aligned bus transactions with byte strobes.
- Stalls the pipeline until the access completes, then returns zero-extended (LBU) or full-word (LW) load data.
- Flags misaligned word accesses and bus timeouts instead of hanging.

Parameters:
- TIMEOUT, 16: maximum cycles in REQ waiting for mem_ack before abort; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- MemRead  in  1  MEM-stage load (ResultSrc==01).
- MemWrite  in  1  MEM-stage store.
- AddrMode  in  1  0 = word (LW/SW), 1 = byte (LBU/SB).
- addr  in  32  byte address from ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  holds the pipeline while an access is pending.
- rdata  out  32  load result to writeback.
- rdata_valid  out  1  rdata valid (one cycle).
- err_misalign  out  1  one-cycle pulse: word access with addr[1:0]!=0.
- err_timeout  out  1  one-cycle pulse: no ack within TIMEOUT cycles.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  bus write enable, registered.
- mem_addr  out  32  {addr[31:2],2'b00}, registered.
- mem_wdata  out  32  bus write data, registered.
- mem_wstrb  out  4  byte enables, registered.
- mem_ack  in  1  bus completion, single cycle.
- mem_rdata  in  32  bus read data, valid with mem_ack.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is IDLE and the timeout counter is 0.
  - Reset mid-access drops mem_req on the same edge.
  - A mem_ack arriving in IDLE is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - access = MemRead|MemWrite; stall = access (combinational).
  - If MemWrite and MemRead are both 1, MemWrite wins (store).
  - Misaligned access (AddrMode=0 and addr[1:0]!=0): go to DONE with err_misalign=1; no bus request; rdata=0.
  - Otherwise go to REQ and register the bus outputs:
    - mem_req=1; mem_we=MemWrite; mem_addr=word address.
    - Word: mem_wstrb=4'b1111 on writes, 0 on reads.
    - Byte write: mem_wstrb=one-hot(addr[1:0]); mem_wdata={4{wdata[7:0]}}.
    - Word write: mem_wdata=wdata.
- REQ:
  - stall=1; mem_req and all bus outputs held stable until ack.
  - On mem_ack:
    - Read: capture rdata. Word gives mem_rdata. Byte gives {24'b0, lane[addr[1:0]]}, where lane 0 = bits[7:0] and lane 3 = bits[31:24].
    - Go to DONE and drop mem_req on the same edge.
  - If the counter reaches TIMEOUT-1 without ack: go to DONE, err_timeout=1, rdata=0, mem_req dropped.
  - The counter increments each REQ cycle and clears on leaving REQ.
- DONE:
  - stall=0.
  - rdata_valid=1 for a completed read or a misaligned read; 0 for writes.
  - err_* pulses are asserted here only.
  - Always returns to IDLE.
  - The MemRead/MemWrite still asserted in DONE belong to the same instruction and must not retrigger.
- Latency:
  - Aligned access with ack on the first REQ cycle: 3 cycles (IDLE, REQ, DONE); pipeline advances at the end of DONE.
  - Each extra wait cycle adds 1.
  - Misaligned access: 2 cycles.
- addr, wdata and AddrMode are sampled only in IDLE; later changes are ignored until the next IDLE.
- rdata holds its last value outside DONE.

Test Plan:
- LW addr=0x100, ack on first REQ cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, stall high 2 cycles, DONE rdata=0xDEADBEEF, rdata_valid=1.
- LBU addr=0x103, mem_rdata=0xA1B2C3D4 -> mem_addr=0x100, rdata=0x000000A1; addr=0x101 -> rdata=0x000000C3.
- SB addr=0x202, wdata=0x12345678, ack after 3 wait cycles -> mem_wstrb=4'b0100, mem_wdata=0x78787878, bus held stable, stall 5 cycles, rdata_valid=0.
- SW addr=0x006 -> no mem_req, err_misalign pulse in cycle 2, stall 1 cycle, back to IDLE.
- LW with ack never asserted, TIMEOUT=4 -> mem_req high exactly 4 cycles, err_timeout=1, rdata=0, stall released.
- rst asserted in the 2nd REQ cycle, then ack the cycle after -> mem_req=0 after the edge, ack ignored, no rdata_valid, all outputs 0.
